// File: rtl/rng_pkg.sv
// Shared types for the dice generator and its result tracker.
package rng_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/result_hist_fifo.sv
// Circular history of settled rolls. Overwrites the oldest entry when full
// and presents the oldest entry on a registered first-word-fall-through output.
module result_hist_fifo #(
  parameter int DATA_W     = 4,
  parameter int HIST_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic [$clog2(HIST_DEPTH):0]   count,
  output logic                          empty,
  output logic                          overflow
);

  localparam int PW = $clog2(HIST_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [HIST_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr_n;
  logic              full;
  logic              do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(HIST_DEPTH));
  assign do_pop = pop && !empty;

  // A push into a full buffer evicts the oldest entry, so rd_ptr moves too.
  // When full, rd_ptr == wr_ptr, which makes push+pop on full identical to
  // the not-full push+pop case.
  always_comb begin
    rd_ptr_n = rd_ptr;
    if (do_pop || (push && full)) begin
      rd_ptr_n = rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dout     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_n;
      if (push && !do_pop && !full) begin
        count <= count + CW'(1);
      end else if (do_pop && !push) begin
        count <= count - CW'(1);
      end
      if (push && full && !do_pop) begin
        overflow <= 1'b1;
      end
      // Bypass the incoming word when it becomes the oldest entry.
      dout <= (push && (rd_ptr_n == wr_ptr)) ? din : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/roll_result_tracker.sv
// Watches the live dice value after a start press, declares the roll settled
// after SETTLE_CYCLES unchanged cycles, publishes it and logs it to history.
module roll_result_tracker #(
  parameter int DATA_W        = rng_pkg::DATA_W,
  parameter int SETTLE_CYCLES = 33554432,
  parameter int HIST_DEPTH    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [DATA_W-1:0]             i_value,
  input  logic                          i_rd,
  output logic                          o_busy,
  output logic [DATA_W-1:0]             o_result,
  output logic                          o_result_valid,
  output logic [3:0]                    o_change_cnt,
  output logic [DATA_W-1:0]             o_hist_data,
  output logic                          o_hist_valid,
  output logic [$clog2(HIST_DEPTH):0]   o_hist_count,
  output logic                          o_overflow
);

  import rng_pkg::*;

  localparam int             QW         = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [QW-1:0]  QUIET_LAST = QW'(SETTLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_r;
  state_t              state_n;
  logic [DATA_W-1:0]   prev_r;
  logic [QW-1:0]       quiet_r;
  logic [CNT_W-1:0]    change_cnt_r;
  logic [DATA_W-1:0]   result_r;
  logic                result_vld_r;
  logic                restart;
  logic                changed;
  logic                settle;
  logic                hist_empty;

  // Start wins over both a value change and the settle event.
  always_comb begin
    state_n = state_r;
    restart = 1'b0;
    changed = 1'b0;
    settle  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          restart = 1'b1;
          state_n = S_TRACK;
        end
      end
      S_TRACK: begin
        if (i_start) begin
          restart = 1'b1;
        end else if (i_value != prev_r) begin
          changed = 1'b1;
        end else if (quiet_r == QUIET_LAST) begin
          settle  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      quiet_r      <= '0;
      change_cnt_r <= '0;
      result_r     <= '0;
      result_vld_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      result_vld_r <= settle;
      if (restart || changed) begin
        quiet_r <= '0;
      end else if ((state_r == S_TRACK) && !settle) begin
        quiet_r <= quiet_r + QW'(1);
      end
      if (restart) begin
        change_cnt_r <= '0;
      end else if (changed) begin
        change_cnt_r <= sat_inc(change_cnt_r);
      end
      if (settle) begin
        result_r <= i_value;
      end
    end
  end

  // prev_r is always loaded on a start before it is compared.
  always_ff @(posedge i_clk) begin
    if (restart || changed) begin
      prev_r <= i_value;
    end
  end

  result_hist_fifo #(
    .DATA_W     (DATA_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push     (settle),
    .pop      (i_rd),
    .din      (i_value),
    .dout     (o_hist_data),
    .count    (o_hist_count),
    .empty    (hist_empty),
    .overflow (o_overflow)
  );

  assign o_busy         = (state_r == S_TRACK);
  assign o_result       = result_r;
  assign o_result_valid = result_vld_r;
  assign o_change_cnt   = change_cnt_r;
  assign o_hist_valid   = !hist_empty;

endmodule

// File: tb/tb_roll_result_tracker.sv
// Bench for roll_result_tracker with SETTLE_CYCLES=8 against a queue-based roll model.
module tb_roll_result_tracker;

  localparam int DW = 4;
  localparam int SC = 8;
  localparam int HD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] value = '0;

  logic          busy;
  logic [DW-1:0] result;
  logic          result_valid;
  logic [3:0]    change_cnt;
  logic [DW-1:0] hist_data;
  logic          hist_valid;
  logic [2:0]    hist_count;
  logic          overflow;

  always #5 clk = ~clk;

  roll_result_tracker #(
    .DATA_W        (DW),
    .SETTLE_CYCLES (SC),
    .HIST_DEPTH    (HD)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_value        (value),
    .i_rd           (rd),
    .o_busy         (busy),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_change_cnt   (change_cnt),
    .o_hist_data    (hist_data),
    .o_hist_valid   (hist_valid),
    .o_hist_count   (hist_count),
    .o_overflow     (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: roll settles SC edges after the last capture of the value.
  int            edge_n = 0;
  bit            m_busy;
  logic [DW-1:0] m_prev;
  int            m_last;
  logic [3:0]    m_cnt;
  logic [DW-1:0] m_result;
  bit            m_valid;
  logic [DW-1:0] q[$];
  bit            m_ovf;

  task automatic model_reset();
    m_busy = 0; m_prev = '0; m_last = 0; m_cnt = '0;
    m_result = '0; m_valid = 0; q.delete(); m_ovf = 0;
  endtask

  task automatic step();
    bit            pop_ok;
    bit            push;
    logic [DW-1:0] tmp;
    @(posedge clk);
    edge_n++;
    pop_ok  = rd && (q.size() > 0);
    push    = 0;
    m_valid = 0;
    if (start) begin
      m_busy = 1; m_prev = value; m_last = edge_n; m_cnt = '0;
    end else if (m_busy) begin
      if (value != m_prev) begin
        m_prev = value; m_last = edge_n;
        if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
      end else if (edge_n - m_last == SC) begin
        m_result = value; m_valid = 1; push = 1; m_busy = 0;
      end
    end
    if (pop_ok) tmp = q.pop_front();
    if (push) begin
      if (q.size() == HD) begin
        tmp = q.pop_front();
        m_ovf = 1;
      end
      q.push_back(value);
    end
    #1;
  endtask

  task automatic assert_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic roll(input logic [DW-1:0] v);
    start = 1'b1; value = v; step();
    start = 1'b0;
    repeat (SC) step();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy, result, result_valid, change_cnt, hist_data, hist_valid, hist_count, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b res=%h vld=%b cnt=%h hd=%h hv=%b hc=%0d ovf=%b, want all 0",
               busy, result, result_valid, change_cnt, hist_data, hist_valid, hist_count, overflow);
    end
    model_reset();
    release_reset();
    step();
    n_cmp++;
    if (busy !== 1'b0 || hist_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b hc=%0d, want 0/0", busy, hist_count);
    end
  endtask

  task automatic test_basic_roll();
    int seen_at = -1;
    start = 1'b1; value = 4'd5; step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL basic_busy_rise: got %b want 1", busy);
    end
    step(); step();
    value = 4'd9; step();
    for (int j = 4; j <= 20; j++) begin
      step();
      if (result_valid === 1'b1 && seen_at < 0) seen_at = j;
      n_cmp++;
      if (result_valid !== m_valid || busy !== m_busy) begin
        n_err++;
        $display("FAIL basic_pulse step %0d: got vld=%b busy=%b want vld=%b busy=%b",
                 j, result_valid, busy, m_valid, m_busy);
      end
    end
    n_cmp++;
    if (seen_at != 3 + SC) begin
      n_err++; $display("FAIL basic_latency: got step %0d want step %0d", seen_at, 3 + SC);
    end
    n_cmp++;
    if (result !== 4'd9 || change_cnt !== 4'd1 || hist_count !== 3'd1 || hist_data !== 4'd9) begin
      n_err++;
      $display("FAIL basic_final: got res=%h cnt=%0d hc=%0d hd=%h want 9/1/1/9",
               result, change_cnt, hist_count, hist_data);
    end
  endtask

  task automatic test_restart();
    bit early = 0;
    int seen_at = -1;
    start = 1'b1; value = 4'd2; step();
    start = 1'b0;
    value = 4'd3; step();
    repeat (5) begin step(); if (result_valid) early = 1; end
    start = 1'b1; step();
    start = 1'b0;
    if (result_valid) early = 1;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (result_valid === 1'b1 && seen_at < 0) seen_at = j;
    end
    n_cmp++;
    if (early) begin
      n_err++; $display("FAIL restart_no_pulse: got a pulse before restart completion, want none");
    end
    n_cmp++;
    if (seen_at != SC) begin
      n_err++; $display("FAIL restart_latency: got step %0d want %0d", seen_at, SC);
    end
    n_cmp++;
    if (change_cnt !== 4'd0 || result !== 4'd3) begin
      n_err++; $display("FAIL restart_final: got cnt=%0d res=%h want 0/3", change_cnt, result);
    end
    // Start exactly on the settle edge suppresses the result.
    early = 0;
    start = 1'b1; value = 4'd4; step();
    start = 1'b0;
    repeat (SC - 1) step();
    start = 1'b1; step();
    start = 1'b0;
    if (result_valid) early = 1;
    n_cmp++;
    if (early || busy !== 1'b1 || result !== 4'd3) begin
      n_err++;
      $display("FAIL restart_priority: got vld=%b busy=%b res=%h want 0/1/3", early, busy, result);
    end
    repeat (SC) step();
  endtask

  task automatic test_saturation();
    start = 1'b1; value = 4'd0; step();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      value = 4'(i);
      step();
    end
    repeat (SC) step();
    n_cmp++;
    if (result_valid !== 1'b1 || change_cnt !== 4'd15 || result !== 4'd4) begin
      n_err++;
      $display("FAIL saturation: got vld=%b cnt=%0d res=%h want 1/15/4", result_valid, change_cnt, result);
    end
  endtask

  task automatic test_overflow();
    assert_reset();
    release_reset();
    for (int v = 1; v <= 5; v++) roll(4'(v));
    n_cmp++;
    if (hist_count !== 3'd4 || overflow !== 1'b1 || hist_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_state: got hc=%0d ovf=%b hv=%b want 4/1/1", hist_count, overflow, hist_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (hist_data !== 4'(k + 2)) begin
        n_err++; $display("FAIL overflow_pop%0d: got %h want %h", k, hist_data, 4'(k + 2));
      end
      rd = 1'b1; step(); rd = 1'b0;
    end
    n_cmp++;
    if (hist_valid !== 1'b0 || hist_count !== 3'd0) begin
      n_err++; $display("FAIL overflow_drained: got hv=%b hc=%0d want 0/0", hist_valid, hist_count);
    end
    rd = 1'b1; step(); rd = 1'b0;
    n_cmp++;
    if (hist_count !== 3'd0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL pop_empty: got hc=%0d ovf=%b want 0/1", hist_count, overflow);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want [4] = '{4'd2, 4'd3, 4'd4, 4'd7};
    assert_reset();
    release_reset();
    for (int v = 1; v <= 4; v++) roll(4'(v));
    start = 1'b1; value = 4'd7; step();
    start = 1'b0;
    repeat (SC - 1) step();
    rd = 1'b1; step(); rd = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b1 || hist_count !== 3'd4 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL collision_state: got vld=%b hc=%0d ovf=%b want 1/4/0", result_valid, hist_count, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (hist_data !== want[k]) begin
        n_err++; $display("FAIL collision_pop%0d: got %h want %h", k, hist_data, want[k]);
      end
      rd = 1'b1; step(); rd = 1'b0;
    end
  endtask

  task automatic test_reset_midroll();
    bit pulse = 0;
    assert_reset();
    release_reset();
    roll(4'd6);
    n_cmp++;
    if (hist_count !== 3'd1 || hist_data !== 4'd6) begin
      n_err++; $display("FAIL midroll_setup: got hc=%0d hd=%h want 1/6", hist_count, hist_data);
    end
    start = 1'b1; value = 4'd8; step();
    start = 1'b0;
    step(); step();
    assert_reset();
    n_cmp++;
    if ({busy, result, result_valid, change_cnt, hist_data, hist_valid, hist_count, overflow} !== '0) begin
      n_err++;
      $display("FAIL midroll_reset: got busy=%b res=%h vld=%b cnt=%h hd=%h hv=%b hc=%0d ovf=%b, want all 0",
               busy, result, result_valid, change_cnt, hist_data, hist_valid, hist_count, overflow);
    end
    release_reset();
    repeat (SC + 4) begin step(); if (result_valid) pulse = 1; end
    n_cmp++;
    if (pulse || busy !== 1'b0 || hist_count !== 3'd0) begin
      n_err++;
      $display("FAIL midroll_after: got pulse=%b busy=%b hc=%0d want 0/0/0", pulse, busy, hist_count);
    end
  endtask

  task automatic test_random();
    logic [14:0] got;
    logic [14:0] exp;
    assert_reset();
    release_reset();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(39) == 0);
      rd    = ($urandom_range(5) == 0);
      if ($urandom_range(7) == 0) value = 4'($urandom_range(15));
      step();
      got = {busy, result_valid, result, change_cnt, hist_valid, hist_count, overflow};
      exp = {m_busy, m_valid, m_result, m_cnt, (q.size() > 0), 3'(q.size()), m_ovf};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_ctl cycle %0d: got %h want %h", i, got, exp);
      end
      if (q.size() > 0) begin
        n_cmp++;
        if (hist_data !== q[0]) begin
          n_err++; $display("FAIL random_hist cycle %0d: got %h want %h", i, hist_data, q[0]);
        end
      end
    end
    start = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_roll();
    test_restart();
    test_saturation();
    test_overflow();
    test_collision();
    test_reset_midroll();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
